// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helper and default level constants for the FIFO family.
package fifo_pkg;
  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 16;
  localparam int AF_MARGIN = 2;
  localparam int AE_DEFAULT = 2;
  function automatic int cw(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, sync write port, async read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_param.sv
// fifo_param: parameterised sync FIFO with count, almost flags, error pulses and optional FWFT read.
module fifo_param import fifo_pkg::*; #(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int AF_LEVEL = DEPTH - AF_MARGIN,
  parameter int AE_LEVEL = AE_DEFAULT,
  parameter int FWFT     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [WIDTH-1:0]        din,
  input  logic                    rd,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cw(DEPTH)-1:0]    count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int CW = cw(DEPTH);
  localparam int AW = CW - 1;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, underflow_q, wr_ok, rd_ok;
  logic [WIDTH-1:0] rdata;
  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign wr_ok   = wr && !full;
  assign rd_ok   = rd && !empty;
  assign wptr_d  = wptr_q + AW'(wr_ok);
  assign rptr_d  = rptr_q + AW'(rd_ok);
  assign count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= wr && full;
      underflow_q <= rd && empty;
    end
  // The write strobe is masked by rst so a write in the reset cycle cannot land in the array.
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rptr_q),
    .rdata (rdata)
  );
  if (FWFT != 0) begin : g_fwft
    assign dout = rdata;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) dout_q <= '0;
      else if (rd_ok) dout_q <= rdata;
    assign dout = dout_q;
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard bench driving a standard and an FWFT instance with directed vectors.
module tb_fifo_param;
  logic clk = 0, rst = 1;
  logic s_wr = 0, s_rd = 0, f_wr = 0, f_rd = 0;
  logic [7:0] s_din = 0, f_din = 0, s_dout, f_dout;
  logic [2:0] s_count, f_count;
  logic s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  int cyc = 0, tag = 0, n_cmp = 0, n_bad = 0;

  typedef struct {
    int         cyc;
    bit         inst;
    bit         chkd;
    logic [7:0] d;
    int         cnt;
    bit         ovf;
    bit         unf;
    int         tag;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr(s_wr), .din(s_din), .rd(s_rd), .dout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf));

  fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(f_wr), .din(f_din), .rd(f_rd), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf));

  task automatic chk(input int t, input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL step%0d %s: got %0h expected %0h", t, nm, got, want);
    end
  endtask

  task automatic chk_all(input int t, input bit inst, input bit chkd, input logic [7:0] d,
                         input int cnt, input bit ovf, input bit unf);
    chk(t, "count",        32'(inst ? f_count : s_count), 32'(cnt));
    chk(t, "full",         32'(inst ? f_full  : s_full),  32'(cnt == 4));
    chk(t, "empty",        32'(inst ? f_empty : s_empty), 32'(cnt == 0));
    chk(t, "almost_full",  32'(inst ? f_af    : s_af),    32'(cnt >= 3));
    chk(t, "almost_empty", 32'(inst ? f_ae    : s_ae),    32'(cnt <= 1));
    chk(t, "overflow",     32'(inst ? f_ovf   : s_ovf),   32'(ovf));
    chk(t, "underflow",    32'(inst ? f_unf   : s_unf),   32'(unf));
    if (chkd) chk(t, "dout", 32'(inst ? f_dout : s_dout), 32'(d));
  endtask

  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk_all(e.tag, e.inst, e.chkd, e.d, e.cnt, e.ovf, e.unf);
    end

  task automatic step(input bit inst, input bit w, input logic [7:0] di, input bit r,
                      input int ecnt, input bit chkd, input logic [7:0] ed, input bit eo, input bit eu);
    if (inst) begin f_wr = w; f_din = di; f_rd = r; end
    else begin s_wr = w; s_din = di; s_rd = r; end
    q.push_back('{cyc + 1, inst, chkd, ed, ecnt, eo, eu, tag});
    tag++;
    @(posedge clk);
    #1;
    s_wr = 0; s_rd = 0; f_wr = 0; f_rd = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 0, 1, 8'h00, 0, 0, 0);
    chk_all(-1, 1, 0, 8'h00, 0, 0, 0);
    rst = 0;
    // Fill to full, then one rejected write
    step(0, 1, 8'hAA, 0, 1, 1, 8'h00, 0, 0);
    step(0, 1, 8'hBB, 0, 2, 1, 8'h00, 0, 0);
    step(0, 1, 8'hCC, 0, 3, 1, 8'h00, 0, 0);
    step(0, 1, 8'hDD, 0, 4, 1, 8'h00, 0, 0);
    step(0, 1, 8'hEE, 0, 4, 1, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 4, 1, 8'h00, 0, 0);
    // Drain with registered reads, then one rejected read
    step(0, 0, 8'h00, 1, 3, 1, 8'hAA, 0, 0);
    step(0, 0, 8'h00, 1, 2, 1, 8'hBB, 0, 0);
    step(0, 0, 8'h00, 1, 1, 1, 8'hCC, 0, 0);
    step(0, 0, 8'h00, 1, 0, 1, 8'hDD, 0, 0);
    step(0, 0, 8'h00, 1, 0, 1, 8'hDD, 0, 1);
    step(0, 0, 8'h00, 0, 0, 1, 8'hDD, 0, 0);
    // Simultaneous wr/rd at empty, at count 2, and at full
    step(0, 1, 8'h11, 1, 1, 1, 8'hDD, 0, 1);
    step(0, 1, 8'h22, 0, 2, 1, 8'hDD, 0, 0);
    step(0, 1, 8'h33, 1, 2, 1, 8'h11, 0, 0);
    step(0, 1, 8'h44, 1, 2, 1, 8'h22, 0, 0);
    step(0, 1, 8'h55, 0, 3, 1, 8'h22, 0, 0);
    step(0, 1, 8'h66, 0, 4, 1, 8'h22, 0, 0);
    step(0, 1, 8'h77, 1, 3, 1, 8'h33, 1, 0);
    step(0, 0, 8'h00, 0, 3, 1, 8'h33, 0, 0);
    step(0, 0, 8'h00, 1, 2, 1, 8'h44, 0, 0);
    step(0, 0, 8'h00, 1, 1, 1, 8'h55, 0, 0);
    step(0, 0, 8'h00, 1, 0, 1, 8'h66, 0, 0);
    // Wrap-around at full throughput
    step(0, 1, 8'h00, 0, 1, 1, 8'h66, 0, 0);
    for (int i = 1; i < 10; i++) step(0, 1, 8'(i), 1, 1, 1, 8'(i - 1), 0, 0);
    step(0, 0, 8'h00, 1, 0, 1, 8'h09, 0, 0);
    // Async reset mid-burst at count 3, with a write held through the reset edge
    step(0, 1, 8'h01, 0, 1, 1, 8'h09, 0, 0);
    step(0, 1, 8'h02, 0, 2, 1, 8'h09, 0, 0);
    step(0, 1, 8'h03, 0, 3, 1, 8'h09, 0, 0);
    @(negedge clk);
    #1;
    rst = 1; s_wr = 1; s_din = 8'h77;
    #1;
    chk_all(-2, 0, 1, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all(-3, 0, 1, 8'h00, 0, 0, 0);
    rst = 0; s_wr = 0;
    step(0, 1, 8'h5A, 0, 1, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0, 1, 8'h5A, 0, 0);
    // FWFT instance
    step(1, 1, 8'h11, 0, 1, 1, 8'h11, 0, 0);
    step(1, 1, 8'h22, 0, 2, 1, 8'h11, 0, 0);
    step(1, 0, 8'h00, 1, 1, 1, 8'h22, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
    step(1, 1, 8'h33, 1, 1, 1, 8'h33, 0, 1);
    step(1, 0, 8'h00, 0, 1, 1, 8'h33, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
